pad_event_reader: RTL and testbench

- Receive side of the virtual pad: takes the concatenated raw pad vector assembled from the four remote boards.
- Synchronises and debounces each bit independently.
- Turns every debounced transition into a press/release event and queues events in a small FIFO.
- Drains events to the application with a valid/ready handshake, so software-visible logic never samples raw, skewed, bouncing pad bits.

---
 rtl/pad_event_reader_if.sv | 15 +
 rtl/pad_event_reader.sv | 149 ++++++++++++++
 tb/tb_pad_event_reader.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pad_event_reader_if.sv
// Event handshake bus between the pad event reader and its consumer.
// The reader drives valid/index/press; the consumer drives ready.
interface pad_event_reader_if #(
  parameter int WIDTH = 16
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic          evt_valid;
  logic          evt_ready;
  logic [IW-1:0] evt_index;
  logic          evt_press;

  modport master (output evt_valid, evt_index, evt_press, input evt_ready);
  modport slave  (input evt_valid, evt_index, evt_press, output evt_ready);
endinterface

// File: rtl/pad_event_reader.sv
// Virtual pad receive side: per-bit synchroniser + debouncer, a pending-change
// mask scanned lowest-index first, and a small event FIFO drained by valid/ready.

// One pad bit: 2-flop synchroniser and consecutive-cycle debounce counter.
// tgl pulses on the edge where stable flips.
module pad_event_lane #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad,
  output logic stable,
  output logic tgl
);
  localparam int CW = $clog2(DEBOUNCE + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          hit;

  assign hit = (cnt == CW'(DEBOUNCE - 1));
  assign tgl = (sync[1] != stable) && hit;

  // Synchronise the raw bit and accept a change only after DEBOUNCE differing cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= '0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync <= {sync[0], pad};
      if (sync[1] == stable) begin
        cnt <= '0;
      end else if (hit) begin
        cnt    <= '0;
        stable <= ~stable;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module pad_event_reader #(
  parameter int WIDTH    = 16,
  parameter int DEBOUNCE = 4,
  parameter int DEPTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         pad_val,
  pad_event_reader_if.master       evt,
  output logic [WIDTH-1:0]         stable_val,
  output logic [$clog2(DEPTH):0]   evt_count,
  output logic                     overflow,
  input  logic                     clear_ovf
);
  localparam int IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic          press;
  } evt_t;

  logic [WIDTH-1:0] tgl;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] clr_mask;
  logic             scan_hit;
  logic [IW-1:0]    scan_idx;
  logic             push;
  logic             pop;
  logic             full;
  logic             coalesce;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  evt_t             mem [DEPTH];
  evt_t             head;

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    pad_event_lane #(.DEBOUNCE(DEBOUNCE)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .pad    (pad_val[g]),
      .stable (stable_val[g]),
      .tgl    (tgl[g])
    );
  end

  // Priority scan: lowest-index pending bit wins this cycle's push slot.
  always_comb begin
    scan_hit = 1'b0;
    scan_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending[i]) begin
        scan_hit = 1'b1;
        scan_idx = IW'(i);
      end
    end
  end

  assign full     = (evt_count == CNTW'(DEPTH));
  assign pop      = evt.evt_valid && evt.evt_ready;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign push     = scan_hit && (!full || pop);
  assign clr_mask = push ? ({{(WIDTH-1){1'b0}}, 1'b1} << scan_idx) : '0;
  // A bit re-debouncing while its previous change still waits is merged.
  assign coalesce = |(tgl & pending & ~clr_mask);

  // Pending mask and sticky overflow; a new toggle beats the scanner's clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      pending <= (pending & ~clr_mask) | tgl;
      if (coalesce)       overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
    end
  end

  // FIFO pointers and exact occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      evt_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   evt_count <= evt_count + 1'b1;
        2'b01:   evt_count <= evt_count - 1'b1;
        default: evt_count <= evt_count;
      endcase
    end
  end

  // Event storage; the event carries the debounced level at push time.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{idx: scan_idx, press: stable_val[scan_idx]};
  end

  assign head          = mem[rd_ptr];
  assign evt.evt_valid = (evt_count != '0);
  assign evt.evt_index = evt.evt_valid ? head.idx   : '0;
  assign evt.evt_press = evt.evt_valid ? head.press : 1'b0;
endmodule

// File: tb/tb_pad_event_reader.sv
// Self-checking bench for pad_event_reader: vector table, directed corner
// sequences and a randomized run against a sliding-window reference model.
module tb_pad_event_reader;
  localparam int WIDTH = 16;
  localparam int DEB   = 4;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pad_val = '0;
  logic [15:0] stable_val;
  logic [3:0]  evt_count;
  logic        overflow;
  logic        clear_ovf = 1'b0;

  pad_event_reader_if #(.WIDTH(WIDTH)) evt_if ();

  pad_event_reader #(.WIDTH(WIDTH), .DEBOUNCE(DEB), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pad_val    (pad_val),
    .evt        (evt_if),
    .stable_val (stable_val),
    .evt_count  (evt_count),
    .overflow   (overflow),
    .clear_ovf  (clear_ovf)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [15:0] pad;
    logic        rdy;
    logic [7:0]  n;
    logic [15:0] stable;
    logic        valid;
    logic [3:0]  idx;
    logic        press;
    logic [3:0]  cnt;
    logic        ovf;
  } vec_t;

  typedef struct packed {
    logic [3:0] idx;
    logic       press;
  } ev_t;

  vec_t        vt [15];
  logic [3:0]  gi [$];
  logic        gp [$];
  ev_t         expq [$];
  logic [15:0] hist [$];
  logic [15:0] m_stable;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset pulse asserted and released between clock edges.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  // Gather up to n transferred events within a cycle budget.
  task automatic collect(input int n, input int budget);
    logic v, r, p;
    logic [3:0] i;
    gi.delete();
    gp.delete();
    for (int c = 0; c < budget && gi.size() < n; c++) begin
      v = evt_if.evt_valid; r = evt_if.evt_ready;
      i = evt_if.evt_index; p = evt_if.evt_press;
      tick();
      if (v && r) begin
        gi.push_back(i);
        gp.push_back(p);
      end
    end
  endtask

  // Reference: a bit's level flips once the last DEB synchronised samples
  // (pad delayed two edges) all differ from it; each flip is one expected event.
  task automatic model_edge();
    logic all_diff;
    hist.push_back(pad_val);
    while (hist.size() > DEB + 2) void'(hist.pop_front());
    for (int b = 0; b < WIDTH; b++) begin
      all_diff = 1'b1;
      for (int k = 0; k < DEB; k++)
        if (hist[k][b] == m_stable[b]) all_diff = 1'b0;
      if (all_diff) begin
        m_stable[b] = ~m_stable[b];
        expq.push_back('{idx: 4'(b), press: m_stable[b]});
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    evt_if.evt_ready = 1'b0;
    //        pad       rdy  n    stable    vld idx    prs cnt   ovf
    vt[0]  = '{16'h0000, 1'b0, 8'd3,  16'h0000, 1'b0, 4'd0,  1'b0, 4'd0, 1'b0};
    vt[1]  = '{16'h0008, 1'b1, 8'd5,  16'h0000, 1'b0, 4'd0,  1'b0, 4'd0, 1'b0};
    vt[2]  = '{16'h0008, 1'b1, 8'd1,  16'h0008, 1'b0, 4'd0,  1'b0, 4'd0, 1'b0};
    vt[3]  = '{16'h0008, 1'b1, 8'd1,  16'h0008, 1'b1, 4'd3,  1'b1, 4'd1, 1'b0};
    vt[4]  = '{16'h0008, 1'b1, 8'd1,  16'h0008, 1'b0, 4'd0,  1'b0, 4'd0, 1'b0};
    vt[5]  = '{16'h0000, 1'b0, 8'd7,  16'h0000, 1'b1, 4'd3,  1'b0, 4'd1, 1'b0};
    vt[6]  = '{16'h0000, 1'b1, 8'd1,  16'h0000, 1'b0, 4'd0,  1'b0, 4'd0, 1'b0};
    vt[7]  = '{16'h0020, 1'b1, 8'd3,  16'h0000, 1'b0, 4'd0,  1'b0, 4'd0, 1'b0};
    vt[8]  = '{16'h0000, 1'b1, 8'd10, 16'h0000, 1'b0, 4'd0,  1'b0, 4'd0, 1'b0};
    vt[9]  = '{16'h8001, 1'b0, 8'd7,  16'h8001, 1'b1, 4'd0,  1'b1, 4'd1, 1'b0};
    vt[10] = '{16'h8001, 1'b0, 8'd1,  16'h8001, 1'b1, 4'd0,  1'b1, 4'd2, 1'b0};
    vt[11] = '{16'h8001, 1'b0, 8'd20, 16'h8001, 1'b1, 4'd0,  1'b1, 4'd2, 1'b0};
    vt[12] = '{16'h8001, 1'b1, 8'd1,  16'h8001, 1'b1, 4'd15, 1'b1, 4'd1, 1'b0};
    vt[13] = '{16'h8001, 1'b1, 8'd1,  16'h8001, 1'b0, 4'd0,  1'b0, 4'd0, 1'b0};
    vt[14] = '{16'h0000, 1'b1, 8'd12, 16'h0000, 1'b0, 4'd0,  1'b0, 4'd0, 1'b0};

    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    // Vector table: single press/release, glitch reject, multi-bit ordering.
    for (int v = 0; v < 15; v++) begin
      pad_val = vt[v].pad;
      evt_if.evt_ready = vt[v].rdy;
      repeat (int'(vt[v].n)) tick();
      check($sformatf("v%0d stable", v), 32'(stable_val), 32'(vt[v].stable));
      check($sformatf("v%0d valid", v), 32'(evt_if.evt_valid), 32'(vt[v].valid));
      check($sformatf("v%0d index", v), 32'(evt_if.evt_index), 32'(vt[v].idx));
      check($sformatf("v%0d press", v), 32'(evt_if.evt_press), 32'(vt[v].press));
      check($sformatf("v%0d count", v), 32'(evt_count), 32'(vt[v].cnt));
      check($sformatf("v%0d overflow", v), 32'(overflow), 32'(vt[v].ovf));
    end

    // Full FIFO backpressure: ten staggered presses, two must wait as pending.
    evt_if.evt_ready = 1'b0;
    for (int b = 0; b < 10; b++) begin
      pad_val[b] = 1'b1;
      repeat (6) tick();
    end
    repeat (6) tick();
    check("bp count full", 32'(evt_count), 32'd8);
    check("bp stable", 32'(stable_val), 32'h03FF);
    evt_if.evt_ready = 1'b1;
    collect(10, 40);
    check("bp events", 32'(gi.size()), 32'd10);
    for (int k = 0; k < gi.size() && k < 10; k++) begin
      check($sformatf("bp idx%0d", k), 32'(gi[k]), 32'(k));
      check($sformatf("bp press%0d", k), 32'(gp[k]), 32'd1);
    end
    check("bp overflow", 32'(overflow), 32'd0);
    check("bp drained", 32'(evt_count), 32'd0);

    // Coalescing with a clear held across the merging edge.
    pad_val = '0;
    do_reset();
    evt_if.evt_ready = 1'b0;
    pad_val = 16'hFF00;
    repeat (20) tick();
    check("coal full", 32'(evt_count), 32'd8);
    pad_val[2] = 1'b1;
    repeat (8) tick();
    check("coal ovf before", 32'(overflow), 32'd0);
    pad_val[2] = 1'b0;
    clear_ovf = 1'b1;
    repeat (6) tick();
    check("coal ovf beats clear", 32'(overflow), 32'd1);
    clear_ovf = 1'b0;
    repeat (4) tick();
    check("coal ovf sticky", 32'(overflow), 32'd1);
    check("coal stable", 32'(stable_val), 32'hFF00);
    evt_if.evt_ready = 1'b1;
    collect(9, 30);
    check("coal events", 32'(gi.size()), 32'd9);
    if (gi.size() == 9) begin
      check("coal last idx", 32'(gi[8]), 32'd2);
      check("coal last press", 32'(gp[8]), 32'd0);
    end
    repeat (5) tick();
    check("coal no extra", 32'(evt_if.evt_valid), 32'd0);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    check("coal cleared", 32'(overflow), 32'd0);

    // Asynchronous reset mid-operation discards queued events.
    pad_val = '0;
    do_reset();
    repeat (3) tick();
    evt_if.evt_ready = 1'b0;
    pad_val = 16'h000F;
    repeat (12) tick();
    check("rst queued", 32'(evt_count), 32'd4);
    #3 rst_n = 1'b0;
    #1;
    check("rst valid", 32'(evt_if.evt_valid), 32'd0);
    check("rst count", 32'(evt_count), 32'd0);
    check("rst stable", 32'(stable_val), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (6) tick();
    check("rst edge6 stable", 32'(stable_val), 32'h000F);
    check("rst edge6 valid", 32'(evt_if.evt_valid), 32'd0);
    tick();
    check("rst edge7 valid", 32'(evt_if.evt_valid), 32'd1);
    check("rst edge7 index", 32'(evt_if.evt_index), 32'd0);
    repeat (3) tick();
    check("rst requeued", 32'(evt_count), 32'd4);
    evt_if.evt_ready = 1'b1;
    collect(4, 20);
    check("rst events", 32'(gi.size()), 32'd4);
    for (int k = 0; k < gi.size() && k < 4; k++) begin
      check($sformatf("rst idx%0d", k), 32'(gi[k]), 32'(k));
      check($sformatf("rst press%0d", k), 32'(gp[k]), 32'd1);
    end

    // Randomized single-bit activity against the window model.
    pad_val = '0;
    do_reset();
    repeat (8) tick();
    m_stable = '0;
    hist.delete();
    expq.delete();
    for (int k = 0; k < DEB + 2; k++) hist.push_back(16'h0000);
    for (int c = 0; c < 3000; c++) begin
      logic v, r, p;
      logic [3:0] i;
      int found;
      if (c < 2950) begin
        if ($urandom_range(2) == 0) begin
          int b;
          b = int'($urandom_range(15));
          pad_val[b] = ~pad_val[b];
        end
        evt_if.evt_ready = ($urandom_range(3) != 0);
      end else begin
        evt_if.evt_ready = 1'b1;
      end
      v = evt_if.evt_valid; r = evt_if.evt_ready;
      i = evt_if.evt_index; p = evt_if.evt_press;
      @(posedge clk);
      model_edge();
      #1;
      check("rnd stable", 32'(stable_val), 32'(m_stable));
      if (v && r) begin
        found = -1;
        for (int k = 0; k < expq.size(); k++)
          if (found < 0 && expq[k].idx == i) found = k;
        if (found < 0) begin
          tests++;
          fails++;
          $display("FAIL rnd event: got idx %0d press %0d, expected no event", i, p);
        end else begin
          check("rnd press", 32'(p), 32'(expq[found].press));
          expq.delete(found);
        end
      end
    end
    check("rnd leftover", 32'(expq.size()), 32'd0);
    check("rnd overflow", 32'(overflow), 32'd0);
    check("rnd count", 32'(evt_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
